// File: rtl/adbg_cpu_port_arbiter.sv
// Round-robin arbiter sharing one CPU debug-register port (stb/ack) among NB_REQ requesters.
// One transaction in flight; a watchdog completes hung transactions with an error response.
module adbg_cpu_port_arbiter #(
  parameter int unsigned NB_REQ         = 4,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned ID_W          = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic                                 axi_aclk,
  input  logic                                 axi_aresetn,
  input  logic [NB_REQ-1:0]                    req_stb_i,
  input  logic [NB_REQ-1:0]                    req_we_i,
  input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]    req_data_i,
  output logic [NB_REQ-1:0]                    req_ack_o,
  output logic                                 req_err_o,
  output logic [DATA_WIDTH-1:0]                req_data_o,
  output logic                                 cpu_stb_o,
  output logic                                 cpu_we_o,
  output logic [ADDR_WIDTH-1:0]                cpu_addr_o,
  output logic [DATA_WIDTH-1:0]                cpu_data_o,
  input  logic [DATA_WIDTH-1:0]                cpu_data_i,
  input  logic                                 cpu_ack_i,
  output logic [ID_W-1:0]                      grant_id_o,
  output logic                                 busy_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [ID_W-1:0]        r_last_grant;

  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [ID_W-1:0]        w_last_nxt;
  logic [ID_W-1:0]        w_pick;
  logic                   w_timeout;
  logic [NB_REQ-1:0]      w_req_ack_nxt;
  logic                   w_req_err_nxt;
  logic [DATA_WIDTH-1:0]  w_req_data_nxt;
  logic                   w_cpu_stb_nxt;
  logic                   w_cpu_we_nxt;
  logic [ADDR_WIDTH-1:0]  w_cpu_addr_nxt;
  logic [DATA_WIDTH-1:0]  w_cpu_data_nxt;
  logic [ID_W-1:0]        w_grant_nxt;

  // First requesting index after the previous winner, wrapping modulo NB_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NB_REQ-1:0] stb,
                                              input logic [ID_W-1:0]   last);
    logic             found;
    logic [ID_W-1:0]  pick;
    int unsigned      idx;
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 1; i <= NB_REQ; i++) begin
      idx = (32'(last) + i) % NB_REQ;
      if (!found && stb[ID_W'(idx)]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
    return pick;
  endfunction

  assign w_pick    = rr_pick(req_stb_i, r_last_grant);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_last_nxt     = r_last_grant;
    w_req_ack_nxt  = '0;
    w_req_err_nxt  = req_err_o;
    w_req_data_nxt = req_data_o;
    w_cpu_stb_nxt  = 1'b0;
    w_cpu_we_nxt   = cpu_we_o;
    w_cpu_addr_nxt = cpu_addr_o;
    w_cpu_data_nxt = cpu_data_o;
    w_grant_nxt    = grant_id_o;
    case (r_state)
      S_IDLE: begin
        if (|req_stb_i) begin
          w_state_nxt    = S_BUSY;
          w_cnt_nxt      = '0;
          w_cpu_stb_nxt  = 1'b1;
          w_cpu_we_nxt   = req_we_i[w_pick];
          w_cpu_addr_nxt = req_addr_i[w_pick];
          w_cpu_data_nxt = req_data_i[w_pick];
          w_grant_nxt    = w_pick;
          w_last_nxt     = w_pick;
        end
      end
      S_BUSY: begin
        if (cpu_ack_i) begin
          w_state_nxt    = S_RESP;
          w_req_data_nxt = cpu_data_i;
          w_req_err_nxt  = 1'b0;
        end else if (w_timeout) begin
          w_state_nxt    = S_RESP;
          w_req_data_nxt = '1;
          w_req_err_nxt  = 1'b1;
        end else begin
          w_cnt_nxt     = r_cnt + 1'b1;
          w_cpu_stb_nxt = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt               = S_IDLE;
        w_cnt_nxt                 = '0;
        w_req_ack_nxt[grant_id_o] = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= ID_W'(NB_REQ - 1);
      req_ack_o    <= '0;
      req_err_o    <= 1'b0;
      req_data_o   <= '0;
      cpu_stb_o    <= 1'b0;
      cpu_we_o     <= 1'b0;
      cpu_addr_o   <= '0;
      cpu_data_o   <= '0;
      grant_id_o   <= '0;
      busy_o       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_nxt;
      req_ack_o    <= w_req_ack_nxt;
      req_err_o    <= w_req_err_nxt;
      req_data_o   <= w_req_data_nxt;
      cpu_stb_o    <= w_cpu_stb_nxt;
      cpu_we_o     <= w_cpu_we_nxt;
      cpu_addr_o   <= w_cpu_addr_nxt;
      cpu_data_o   <= w_cpu_data_nxt;
      grant_id_o   <= w_grant_nxt;
      busy_o       <= (w_state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_adbg_cpu_port_arbiter.sv
// Directed self-checking bench for adbg_cpu_port_arbiter (4 requesters, 8-cycle watchdog).
module tb_adbg_cpu_port_arbiter;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req_stb;
  logic [3:0]       req_we;
  logic [3:0][15:0] req_addr;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ack;
  logic             req_err;
  logic [31:0]      req_rdata;
  logic             cpu_stb;
  logic             cpu_we;
  logic [15:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             cpu_ack;
  logic [1:0]       grant_id;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  adbg_cpu_port_arbiter #(
    .NB_REQ(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) u_dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .req_stb_i   (req_stb),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_ack_o   (req_ack),
    .req_err_o   (req_err),
    .req_data_o  (req_rdata),
    .cpu_stb_o   (cpu_stb),
    .cpu_we_o    (cpu_we),
    .cpu_addr_o  (cpu_addr),
    .cpu_data_o  (cpu_wdata),
    .cpu_data_i  (cpu_rdata),
    .cpu_ack_i   (cpu_ack),
    .grant_id_o  (grant_id),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advance until a req_ack pulse is seen, counting cycles with cpu_stb high.
  task automatic wait_ack(input int budget, output logic [3:0] ack, output int stb_cycles);
    bit done;
    done       = 1'b0;
    ack        = '0;
    stb_cycles = 0;
    for (int c = 0; c < budget && !done; c++) begin
      if (cpu_stb) stb_cycles++;
      if (req_ack != 4'b0000) begin
        ack  = req_ack;
        done = 1'b1;
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    logic [3:0] a;
    logic [3:0] prev;
    int         n;
    int         g;

    rst_n     = 1'b0;
    req_stb   = '0;
    req_we    = '0;
    req_addr  = '0;
    req_data  = '0;
    cpu_rdata = '0;
    cpu_ack   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 16'h0100 + 16'(i);
      req_data[i] = 32'hD000_0000 + 32'(i);
    end
    tick();
    tick();
    chk("rst_stb",   64'(cpu_stb), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_ack",   64'(req_ack), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_rdata", 64'(req_rdata), 64'd0);
    rst_n = 1'b1;
    tick();

    // T2 fairness: all four held, acked immediately -> 0,1,2,3,0
    req_stb = 4'b1111;
    g       = 0;
    prev    = '0;
    for (int c = 0; c < 80 && g < 5; c++) begin
      tick();
      if (req_ack != 4'b0000) begin
        chk("t2_order", 64'(req_ack), 64'(4'b0001 << (g % 4)));
        chk("t2_grant", 64'(grant_id), 64'(g % 4));
        chk("t2_no_double", 64'(prev & req_ack), 64'd0);
        g++;
        if (g == 5) req_stb = 4'b0000;
      end
      prev    = req_ack;
      cpu_ack = cpu_stb;
    end
    chk("t2_count", 64'(g), 64'd5);
    cpu_ack = 1'b0;
    tick();

    // T1 single read from requester 2, ack two cycles after cpu_stb
    req_stb     = 4'b0100;
    req_we      = 4'b0000;
    req_addr[2] = 16'h0010;
    tick();
    chk("t1_stb",   64'(cpu_stb), 64'd1);
    chk("t1_addr",  64'(cpu_addr), 64'h0010);
    chk("t1_we",    64'(cpu_we), 64'd0);
    chk("t1_grant", 64'(grant_id), 64'd2);
    chk("t1_busy",  64'(busy), 64'd1);
    tick();
    cpu_ack   = 1'b1;
    cpu_rdata = 32'hCAFEF00D;
    tick();
    cpu_ack = 1'b0;
    chk("t1_resp_stb", 64'(cpu_stb), 64'd0);
    chk("t1_resp_ack", 64'(req_ack), 64'd0);
    tick();
    chk("t1_ack",   64'(req_ack), 64'b0100);
    chk("t1_rdata", 64'(req_rdata), 64'hCAFEF00D);
    chk("t1_err",   64'(req_err), 64'd0);
    req_stb = 4'b0000;
    tick();
    chk("t1_ack_end", 64'(req_ack), 64'd0);

    // T3 timeout on a write from requester 1
    req_stb     = 4'b0010;
    req_we      = 4'b0010;
    req_data[1] = 32'h1234_ABCD;
    tick();
    chk("t3_we",    64'(cpu_we), 64'd1);
    chk("t3_wdata", 64'(cpu_wdata), 64'h1234_ABCD);
    wait_ack(30, a, n);
    chk("t3_stb_cycles", 64'(n), 64'd8);
    chk("t3_ack",   64'(a), 64'b0010);
    chk("t3_err",   64'(req_err), 64'd1);
    chk("t3_rdata", 64'(req_rdata), 64'hFFFF_FFFF);
    req_stb = 4'b0000;
    req_we  = 4'b0000;
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("t3_late_busy", 64'(busy), 64'd0);
    chk("t3_late_stb",  64'(cpu_stb), 64'd0);
    tick();
    chk("t3_late_ack", 64'(req_ack), 64'd0);

    // T4 ack arrives on the last watchdog cycle: ack wins
    req_stb     = 4'b1000;
    req_addr[3] = 16'h0BEE;
    tick();
    chk("t4_addr", 64'(cpu_addr), 64'h0BEE);
    repeat (7) tick();
    chk("t4_stb_last", 64'(cpu_stb), 64'd1);
    cpu_ack   = 1'b1;
    cpu_rdata = 32'h1234_5678;
    tick();
    cpu_ack = 1'b0;
    chk("t4_resp_stb", 64'(cpu_stb), 64'd0);
    tick();
    chk("t4_ack",   64'(req_ack), 64'b1000);
    chk("t4_err",   64'(req_err), 64'd0);
    chk("t4_rdata", 64'(req_rdata), 64'h1234_5678);
    req_stb = 4'b0000;
    tick();

    // T6 granted requester withdraws mid-transaction
    req_stb = 4'b0001;
    tick();
    chk("t6_grant", 64'(grant_id), 64'd0);
    req_stb = 4'b0000;
    tick();
    chk("t6_stb_hold1", 64'(cpu_stb), 64'd1);
    tick();
    chk("t6_stb_hold2", 64'(cpu_stb), 64'd1);
    cpu_ack   = 1'b1;
    cpu_rdata = 32'hA5A5_5A5A;
    tick();
    cpu_ack = 1'b0;
    tick();
    chk("t6_ack",   64'(req_ack), 64'b0001);
    chk("t6_rdata", 64'(req_rdata), 64'hA5A5_5A5A);
    tick();

    // T5 asynchronous reset in BUSY, then priority restarts at requester 0
    req_stb = 4'b0100;
    tick();
    chk("t5_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_stb",  64'(cpu_stb), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_ack",  64'(req_ack), 64'd0);
    req_stb = 4'b0000;
    tick();
    chk("t5_rst_ack2", 64'(req_ack), 64'd0);
    rst_n   = 1'b1;
    req_stb = 4'b1010;
    tick();
    chk("t5_grant", 64'(grant_id), 64'd1);
    chk("t5_stb",   64'(cpu_stb), 64'd1);
    req_stb   = 4'b0000;
    cpu_ack   = 1'b1;
    cpu_rdata = 32'h0000_0055;
    tick();
    cpu_ack = 1'b0;
    tick();
    chk("t5_ack", 64'(req_ack), 64'b0010);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
